// File: rtl/zshift_pkg.sv
// Shared types for the zshift history buffer: FSM state encoding and a clog2 helper.
package zshift_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StRd,
        StWr,
        StNxt,
        StTail,
        StFin
    } zshift_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/zshift_rr_arb.sv
// Combinational round-robin picker: first pending channel at or after the start pointer.
module zshift_rr_arb #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned CW   = 1
) (
    input  logic [N_CH-1:0] pend,
    input  logic [CW-1:0]   start,
    output logic [CW-1:0]   grant,
    output logic            valid
);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        // Walk offsets from the far end so the nearest pending channel is the last to win.
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % int'(N_CH);
            if (pend[idx]) begin
                grant = CW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zshift_history_mc.sv
// Multi-channel SDRAM history window: shift each channel's window left by one word, append sample.
// Optional ZSHIFT_WINMAX_EN adds oWinMax, the per-channel window maximum after its last shift.
module zshift_history_mc
    import zshift_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 24,
    parameter int unsigned DEPTH     = 600,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned BASE_ADDR = 384000,
    parameter int unsigned CH_STRIDE = 600,
    localparam int unsigned CW       = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_CH-1:0]    iDataUpdate,
    input  logic [N_CH*DW-1:0] iPulseCounter,
    output logic [AW-1:0]      oSDRAM_Rd_Addr,
    output logic               oSDRAM_Rd_Req,
    input  logic [DW-1:0]      iSDRAM_Rd_Data,
    input  logic               iSDRAM_Rd_Done,
    output logic [AW-1:0]      oSDRAM_Wr_Addr,
    output logic [DW-1:0]      oSDRAM_Wr_Data,
    output logic               oSDRAM_Wr_Req,
    input  logic               iSDRAM_Wr_Done,
    output logic               oBusy,
    output logic               oShiftDone,
    output logic [CW-1:0]      oShiftCh,
    output logic [N_CH-1:0]    oOverrun
`ifdef ZSHIFT_WINMAX_EN
    ,
    output logic [N_CH*DW-1:0] oWinMax
`endif
);

    localparam int unsigned KW = clog2(DEPTH);

    zshift_state_e stateQ, stateD;
    logic [CW-1:0]   chQ, rrQ, lastChQ;
    logic [KW-1:0]   kQ;
    logic [DW-1:0]   curQ, tmpQ;
    logic [N_CH-1:0] pendQ, overrunQ, claim;
    logic [DW-1:0]   pendDataQ [N_CH];
    logic            ackQ, doneNow, armGo;
    logic [CW-1:0]   arbGrant;
    logic            arbValid;

    function automatic logic [AW-1:0] addrOf(input logic [CW-1:0] c, input logic [KW-1:0] k);
        return AW'(BASE_ADDR) + AW'(c) * AW'(CH_STRIDE) + AW'(k);
    endfunction

    zshift_rr_arb #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_arb (
        .pend  (pendQ),
        .start (rrQ),
        .grant (arbGrant),
        .valid (arbValid)
    );

    assign armGo   = (stateQ == StArb) && en && arbValid;
    assign doneNow = ((stateQ == StRd) && iSDRAM_Rd_Done) ||
                     (((stateQ == StWr) || (stateQ == StTail)) && iSDRAM_Wr_Done);

    always_comb begin
        claim = '0;
        if (armGo) begin
            claim[arbGrant] = 1'b1;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (en) begin
            unique case (stateQ)
                StIdle: if (|pendQ) stateD = StArb;
                StArb:  stateD = arbValid ? StRd : StIdle;
                StRd:   if (iSDRAM_Rd_Done || ackQ) stateD = StWr;
                StWr:   if (iSDRAM_Wr_Done || ackQ) stateD = StNxt;
                StNxt:  stateD = (kQ == KW'(DEPTH - 2)) ? StTail : StRd;
                StTail: if (iSDRAM_Wr_Done || ackQ) stateD = StFin;
                StFin:  stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            chQ      <= '0;
            rrQ      <= '0;
            lastChQ  <= '0;
            kQ       <= '0;
            curQ     <= '0;
            tmpQ     <= '0;
            pendQ    <= '0;
            overrunQ <= '0;
            ackQ     <= 1'b0;
            for (int c = 0; c < int'(N_CH); c++) begin
                pendDataQ[c] <= '0;
            end
        end else begin
            stateQ   <= stateD;
            overrunQ <= iDataUpdate & pendQ & ~claim;
            // A fresh update beats a same-cycle claim; the claim takes the old sample.
            for (int c = 0; c < int'(N_CH); c++) begin
                if (iDataUpdate[c]) begin
                    pendQ[c]     <= 1'b1;
                    pendDataQ[c] <= iPulseCounter[c*DW +: DW];
                end else if (claim[c]) begin
                    pendQ[c] <= 1'b0;
                end
            end
            if ((stateQ == StRd) && iSDRAM_Rd_Done) begin
                tmpQ <= iSDRAM_Rd_Data;
            end
            // Remember a completion that lands while the FSM is frozen.
            if (en) begin
                ackQ <= 1'b0;
            end else if (doneNow) begin
                ackQ <= 1'b1;
            end
            if (armGo) begin
                chQ  <= arbGrant;
                curQ <= pendDataQ[arbGrant];
                kQ   <= '0;
                rrQ  <= CW'((int'(arbGrant) + 1) % int'(N_CH));
            end
            if (en && (stateQ == StNxt) && (kQ != KW'(DEPTH - 2))) begin
                kQ <= kQ + KW'(1);
            end
            if (en && (stateQ == StFin)) begin
                lastChQ <= chQ;
            end
        end
    end

`ifdef ZSHIFT_WINMAX_EN
    logic [DW-1:0] maxQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxQ    <= '0;
            oWinMax <= '0;
        end else begin
            if (armGo) begin
                maxQ <= pendDataQ[arbGrant];
            end else if ((stateQ == StRd) && iSDRAM_Rd_Done && (iSDRAM_Rd_Data > maxQ)) begin
                maxQ <= iSDRAM_Rd_Data;
            end
            if (en && (stateQ == StFin)) begin
                oWinMax[chQ*DW +: DW] <= maxQ;
            end
        end
    end
`endif

    always_comb begin
        oSDRAM_Rd_Req  = (stateQ == StRd);
        oSDRAM_Rd_Addr = '0;
        oSDRAM_Wr_Req  = (stateQ == StWr) || (stateQ == StTail);
        oSDRAM_Wr_Addr = '0;
        oSDRAM_Wr_Data = '0;
        if (stateQ == StRd) begin
            oSDRAM_Rd_Addr = addrOf(chQ, kQ + KW'(1));
        end
        if (stateQ == StWr) begin
            oSDRAM_Wr_Addr = addrOf(chQ, kQ);
            oSDRAM_Wr_Data = tmpQ;
        end else if (stateQ == StTail) begin
            oSDRAM_Wr_Addr = addrOf(chQ, KW'(DEPTH - 1));
            oSDRAM_Wr_Data = curQ;
        end
        oBusy      = (stateQ != StIdle) && (stateQ != StFin);
        oShiftDone = (stateQ == StFin);
        oShiftCh   = (stateQ == StFin) ? chQ : lastChQ;
        oOverrun   = overrunQ;
    end

endmodule

// File: tb/tb_zshift_history_mc.sv
// Directed bench for zshift_history_mc with a small SDRAM model answering 3 cycles after a request.
module tb_zshift_history_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  upd = 2'b0;
    logic [31:0] pc = '0;
    logic [23:0] rdAddr, wrAddr;
    logic        rdReq, wrReq, rdDone, wrDone, busy, shiftDone, shiftCh;
    logic [15:0] rdData, wrData;
    logic [1:0]  overrun;
`ifdef ZSHIFT_WINMAX_EN
    logic [31:0] winMax;
`endif

    logic [15:0] mem [256];
    int nChecks = 0, nPass = 0;
    int doneCnt = 0, ovr0 = 0, ovr1 = 0, bothHigh = 0, rdCount = 0, wrCount = 0;
    int rdCnt = 0, wrCnt = 0;
    logic [31:0] rdSig = '0, wrSig = '0;
    logic [7:0]  doneChSig = '0;

    always #5 clk = ~clk;

    zshift_history_mc #(
        .DW        (16),
        .AW        (24),
        .DEPTH     (4),
        .N_CH      (2),
        .BASE_ADDR (100),
        .CH_STRIDE (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .iDataUpdate    (upd),
        .iPulseCounter  (pc),
        .oSDRAM_Rd_Addr (rdAddr),
        .oSDRAM_Rd_Req  (rdReq),
        .iSDRAM_Rd_Data (rdData),
        .iSDRAM_Rd_Done (rdDone),
        .oSDRAM_Wr_Addr (wrAddr),
        .oSDRAM_Wr_Data (wrData),
        .oSDRAM_Wr_Req  (wrReq),
        .iSDRAM_Wr_Done (wrDone),
        .oBusy          (busy),
        .oShiftDone     (shiftDone),
        .oShiftCh       (shiftCh),
        .oOverrun       (overrun)
`ifdef ZSHIFT_WINMAX_EN
        ,
        .oWinMax        (winMax)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkWin(input int base, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        checkVal($sformatf("mem[%0d]", base),     {16'h0, mem[base]},     {16'h0, e0});
        checkVal($sformatf("mem[%0d]", base + 1), {16'h0, mem[base + 1]}, {16'h0, e1});
        checkVal($sformatf("mem[%0d]", base + 2), {16'h0, mem[base + 2]}, {16'h0, e2});
        checkVal($sformatf("mem[%0d]", base + 3), {16'h0, mem[base + 3]}, {16'h0, e3});
    endtask

    task automatic strobe(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk);
        #1;
        upd = mask;
        pc  = {d1, d0};
        @(posedge clk);
        #1;
        upd = 2'b0;
    endtask

    task automatic waitDone(input int target, input string tag);
        int n;
        n = 0;
        while (doneCnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, doneCnt, target);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // SDRAM model: Done pulses on the third cycle a request is held, once per request.
    initial begin
        rdDone = 1'b0;
        wrDone = 1'b0;
        rdData = '0;
        forever begin
            @(posedge clk);
            #1;
            rdDone = 1'b0;
            wrDone = 1'b0;
            if (!rdReq) begin
                rdCnt = 0;
            end else if (rdCnt < 3) begin
                rdCnt++;
                if (rdCnt == 3) begin
                    rdDone = 1'b1;
                    rdData = mem[rdAddr[7:0]];
                    rdCount++;
                    rdSig = {rdSig[23:0], rdAddr[7:0]};
                end
            end
            if (!wrReq) begin
                wrCnt = 0;
            end else if (wrCnt < 3) begin
                wrCnt++;
                if (wrCnt == 3) begin
                    wrDone = 1'b1;
                    mem[wrAddr[7:0]] = wrData;
                    wrCount++;
                    wrSig = {wrSig[23:0], wrAddr[7:0]};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (shiftDone) begin
                doneCnt++;
                doneChSig = {doneChSig[6:0], shiftCh};
            end
            if (overrun[0]) ovr0++;
            if (overrun[1]) ovr1++;
            if (rdReq && wrReq) bothHigh++;
        end
    end

    initial begin
        int n, holdErr, wrBefore, doneBefore;
        logic [23:0] holdAddr;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[100] = 16'd1;  mem[101] = 16'd2;  mem[102] = 16'd3;  mem[103] = 16'd4;
        mem[104] = 16'h11; mem[105] = 16'h12; mem[106] = 16'h13; mem[107] = 16'h14;

        #1 rst = 1'b1;
        #5;
        checkVal("rst_rdReq", rdReq, 0);
        checkVal("rst_wrReq", wrReq, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_shiftDone", shiftDone, 0);
        checkVal("rst_shiftCh", shiftCh, 0);
        checkVal("rst_overrun", overrun, 0);
        checkVal("rst_wrAddr", wrAddr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single shift on channel 0.
        rdSig = '0;
        wrSig = '0;
        strobe(2'b01, 16'h00AA, 16'h0);
        waitDone(1, "single_done");
        checkVal("single_rdSig", rdSig, 32'h0065_6667);
        checkVal("single_wrSig", wrSig, 32'h6465_6667);
        checkVal("single_rdCount", rdCount, 3);
        checkVal("single_wrCount", wrCount, 4);
        checkVal("single_ch", doneChSig[0], 0);
        checkWin(100, 16'd2, 16'd3, 16'd4, 16'h00AA);

        // Simultaneous updates from a fresh pointer.
        pulseReset();
        strobe(2'b11, 16'd5, 16'd7);
        waitDone(3, "simul_done");
        checkVal("simul_order", doneChSig[1:0], 2'b01);
        checkVal("simul_heldCh", shiftCh, 1);
        checkWin(100, 16'd3, 16'd4, 16'h00AA, 16'd5);
        checkWin(104, 16'h12, 16'h13, 16'h14, 16'd7);

        // Overrun on channel 1 while channel 0 shifts.
        strobe(2'b01, 16'h20, 16'h0);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        strobe(2'b10, 16'h0, 16'd8);
        strobe(2'b10, 16'h0, 16'd9);
        waitDone(5, "ovr_done");
        repeat (50) @(negedge clk);
        checkVal("ovr_noExtra", doneCnt, 5);
        checkVal("ovr_pulse1", ovr1, 1);
        checkVal("ovr_pulse0", ovr0, 0);
        checkVal("ovr_order", doneChSig[1:0], 2'b01);
        checkWin(100, 16'd4, 16'h00AA, 16'd5, 16'h20);
        checkWin(104, 16'h13, 16'h14, 16'd7, 16'd9);

        // en gating mid-read.
        strobe(2'b01, 16'h30, 16'h0);
        n = 0;
        while (!rdReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        holdAddr = rdAddr;
        wrBefore = wrCount;
        holdErr = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rdReq || rdAddr !== holdAddr || wrReq || !busy) holdErr++;
        end
        checkVal("en_holdAddr", holdAddr, 24'd101);
        checkVal("en_holdErr", holdErr, 0);
        checkVal("en_noWrite", wrCount, wrBefore);
        en = 1'b1;
        waitDone(6, "en_done");
        checkWin(100, 16'h00AA, 16'd5, 16'h20, 16'h30);

        // Reset in the middle of a write.
        strobe(2'b10, 16'h0, 16'h40);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        strobe(2'b01, 16'h50, 16'h0);
        n = 0;
        while (!wrReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        doneBefore = doneCnt;
        rst = 1'b1;
        #1;
        checkVal("rstmid_wrReq", wrReq, 0);
        checkVal("rstmid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkVal("rstmid_noDone", doneCnt, doneBefore);
        checkVal("rstmid_idle", {busy, rdReq, wrReq}, 3'b000);

`ifdef ZSHIFT_WINMAX_EN
        mem[100] = 16'd1; mem[101] = 16'd9; mem[102] = 16'd3; mem[103] = 16'd4;
        strobe(2'b01, 16'd2, 16'h0);
        waitDone(doneBefore + 1, "wmax_done");
        checkWin(100, 16'd9, 16'd3, 16'd4, 16'd2);
        checkVal("wmax_ch0", winMax[15:0], 16'd9);
`endif

        checkVal("never_both_req", bothHigh, 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/zshift_history_mc.md
Name: zshift_history_mc

Overview:
- Multi-channel, parametrised SDRAM history buffer for photon-counter display traces.
- Each channel owns a DEPTH-word window in SDRAM. On each new sample, the block shifts the window left by one word (read k+1, write k) and appends the new sample at the tail.
- Sits between the pulse counters and the SDRAM read/write glue, beside the LCD GRAM region.

Parameters:
- DW, 16, sample and SDRAM data width.
- AW, 24, SDRAM word address width (Bank+Row+Column).
- DEPTH, 600, words per channel window; must be at least 2.
- N_CH, 2, number of channels.
- BASE_ADDR, 384000, address of channel 0, word 0.
- CH_STRIDE, 600, address distance between channel windows; must be at least DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  FSM advance enable.
- iDataUpdate  in  N_CH  per-channel one-cycle strobe: new sample valid.
- iPulseCounter  in  N_CH*DW  packed samples; channel c occupies bits [c*DW +: DW].
- oSDRAM_Rd_Addr  out  AW  read address.
- oSDRAM_Rd_Req  out  1  read request, level.
- iSDRAM_Rd_Data  in  DW  read data, valid with iSDRAM_Rd_Done.
- iSDRAM_Rd_Done  in  1  one-cycle read-complete pulse.
- oSDRAM_Wr_Addr  out  AW  write address.
- oSDRAM_Wr_Data  out  DW  write data.
- oSDRAM_Wr_Req  out  1  write request, level.
- iSDRAM_Wr_Done  in  1  one-cycle write-complete pulse.
- oBusy  out  1  high while a shift is in progress.
- oShiftDone  out  1  one-cycle pulse when a channel's shift and append completes.
- oShiftCh  out  max(1,$clog2(N_CH))  channel of the last completed shift; held.
- oOverrun  out  N_CH  one-cycle pulse: update arrived while that channel's pending sample was still unserved.

Behaviour:
- Reset (async, rst=1): all outputs 0; pending flags, sample registers and round-robin pointer cleared; FSM to IDLE. Requests drop in the same instant the reset asserts. SDRAM contents are left partially shifted with no recovery.
- Capture: runs independently of en.
  - iDataUpdate[c] loads pend_data[c] and sets pend[c].
  - If pend[c] is already set: overwrite the sample (latest wins) and pulse oOverrun[c].
  - If the FSM claims channel c in the same cycle as a new update: the set wins, the new value is stored, and the claimed value is the old one.
- Address: addr(c,k) = BASE_ADDR + c*CH_STRIDE + k, computed at AW width, no overflow check.
- FSM: states advance only while en=1. With en=0, state and all outputs hold, including asserted requests.
  - IDLE: if any pend is set, go to ARB.
  - ARB: round-robin pick of channel ch, starting at the channel after the last one served. Copy the sample to cur, clear pend[ch], set k=0, oBusy=1, go to RD.
  - RD: oSDRAM_Rd_Req=1, oSDRAM_Rd_Addr=addr(ch,k+1). On Rd_Done: Req=0 in the next cycle, latch data into tmp, go to WR.
  - WR: oSDRAM_Wr_Req=1, Addr=addr(ch,k), Data=tmp. On Wr_Done: Req=0, go to NXT.
  - NXT: if k==DEPTH-2, go to TAIL; else k=k+1 and go to RD.
  - TAIL: write cur to addr(ch,DEPTH-1) with the same handshake as WR, then go to FIN.
  - FIN: pulse oShiftDone, set oShiftCh=ch, oBusy=0, go to IDLE.
- Handshake:
  - A request stays high until its Done pulse; a Done pulse while the request is low is ignored.
  - Rd and Wr requests are never high together.
  - Address and data are stable for the whole time the request is high.
- Per shift: exactly DEPTH-1 reads and DEPTH writes. Minimum cost is 3 cycles per element plus SDRAM latency.

Optional Feature:
- Macro ZSHIFT_WINMAX_EN.
- When defined:
  - Adds output oWinMax (N_CH*DW), the unsigned maximum of each channel's window after its last shift, for display auto-scaling.
  - The running max is seeded with cur at ARB and updated with each read word; it is stored to oWinMax[ch] at FIN.
  - Resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package zshift_pkg: FSM state enum (IDLE, ARB, RD, WR, NXT, TAIL, FIN) and a clog2 helper.
- Parameters stay module-local.
- One sub-module: zshift_rr_arb. Inputs: N_CH pending vector and last-served pointer. Outputs: grant index and valid. Purely combinational.

Test Plan:
Bench setup: DEPTH=4, N_CH=2, BASE_ADDR=100, CH_STRIDE=4; SDRAM model returns Done 3 cycles after the request.
- Single shift: mem[100..103]={1,2,3,4}, update ch0=0x00AA -> reads 101,102,103; writes 100,101,102,103; result mem {2,3,4,0xAA}; oShiftDone pulses once with oShiftCh=0.
- Simultaneous updates: ch0=5 and ch1=7 in the same cycle -> ch0 served first, then ch1 at 104..107, giving mem[107]=7; two oShiftDone pulses, oShiftCh 0 then 1.
- Overrun: two ch1 updates (8, then 9) while ch0 is shifting -> oOverrun[1] pulses once; ch1 tail = 9; only one ch1 shift occurs.
- en gating: drop en for 20 cycles mid-RD -> Rd_Req and Rd_Addr hold; no new transfers start; shift completes correctly after en returns.
- Reset mid-shift: assert rst during WR -> Wr_Req=0 and oBusy=0 immediately; pend cleared; no oShiftDone pulse.
- ZSHIFT_WINMAX_EN: mem {1,9,3,4}, new sample 2 -> final window {9,3,4,2}; oWinMax[0]=9.
